// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Chooses the next PC for the external
//               program_counter register, drives a req/ready handshake with
//               instruction memory, owns the IF/ID pipeline register and a
//               one-entry skid buffer that absorbs a returned instruction
//               while decode is stalled.
//               Optional macro FETCH_PERF_EN adds perf_fetched/perf_bubbles
//               event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    localparam logic [31:0] c_pc_step = 32'd4;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DROP    = 3'd3,
        ST_STALLED = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_target;

    logic        w_req;
    logic [31:0] w_pc_next;
    logic        w_ifid_free;
    logic        w_load_mem;
    logic        w_load_skid;
    logic        w_skid_fill;
    logic        w_flush;
    logic        w_target_load;

    // IF/ID can take a new word when it is empty or decode consumes it now
    assign w_ifid_free = !r_ifid_valid || !stall_id;

    // Next-state, handshake and next-PC decisions; PC holds unless told otherwise
    always_comb begin
        w_state_next  = r_state;
        w_req         = 1'b0;
        w_pc_next     = pc_cur;
        w_load_mem    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_fill   = 1'b0;
        w_flush       = 1'b0;
        w_target_load = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_FETCH;
            end

            ST_FETCH: begin
                if (redirect_valid) begin
                    // No request is outstanding, so the new target can go straight to the PC
                    w_pc_next = redirect_target;
                    w_flush   = 1'b1;
                end else begin
                    w_req = 1'b1;
                    if (imem_ready) begin
                        w_pc_next = pc_cur + c_pc_step;
                        if (w_ifid_free) begin
                            w_load_mem = 1'b1;
                        end else begin
                            w_skid_fill  = 1'b1;
                            w_state_next = ST_STALLED;
                        end
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                w_req = 1'b1;
                if (redirect_valid) begin
                    // Request must stay stable; remember the target and discard its data later
                    w_target_load = 1'b1;
                    w_flush       = 1'b1;
                    w_state_next  = ST_DROP;
                end else if (imem_ready) begin
                    w_pc_next = pc_cur + c_pc_step;
                    if (w_ifid_free) begin
                        w_load_mem   = 1'b1;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_skid_fill  = 1'b1;
                        w_state_next = ST_STALLED;
                    end
                end
            end

            ST_DROP: begin
                w_req = 1'b1;
                if (redirect_valid) begin
                    w_target_load = 1'b1;
                    w_flush       = 1'b1;
                end
                if (imem_ready) begin
                    w_pc_next    = redirect_valid ? redirect_target : r_target;
                    w_state_next = ST_FETCH;
                end
            end

            ST_STALLED: begin
                if (redirect_valid) begin
                    w_flush      = 1'b1;
                    w_pc_next    = redirect_target;
                    w_state_next = ST_FETCH;
                end else if (!stall_id) begin
                    w_load_skid  = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end

            default: begin
                w_state_next = ST_BOOT;
            end
        endcase

        // Reset abandons any outstanding request and parks the PC
        if (rst) begin
            w_req     = 1'b0;
            w_pc_next = RESET_PC;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Skid buffer and pending redirect target capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_pc    <= 32'd0;
            r_skid_instr <= NOP_INSTR;
            r_target     <= RESET_PC;
        end else begin
            if (w_skid_fill) begin
                r_skid_pc    <= pc_cur;
                r_skid_instr <= imem_rdata;
            end
            if (w_target_load) begin
                r_target <= redirect_target;
            end
        end
    end

    // IF/ID register: load from memory or skid, flush on redirect, bubble when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
        end else if (w_load_mem) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= pc_cur;
            r_ifid_instr <= imem_rdata;
        end else if (w_load_skid) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= r_skid_pc;
            r_ifid_instr <= r_skid_instr;
        end else if (w_flush || !stall_id) begin
            r_ifid_valid <= 1'b0;
        end
    end

    assign pc_next    = w_pc_next;
    assign imem_req   = w_req;
    assign imem_addr  = pc_cur;
    assign ifid_valid = r_ifid_valid;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_valid ? r_ifid_instr : NOP_INSTR;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    // Count instructions written into IF/ID and idle decode cycles after boot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 32'd0;
            r_perf_bubbles <= 32'd0;
        end else begin
            if (w_load_mem || w_load_skid) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!r_ifid_valid && !stall_id && (r_state != ST_BOOT)) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed vector table,
//               reset-during-transaction sequence and a randomized run
//               checked against an instruction-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam int          C_NRAND    = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall_id;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    logic [31:0] key;
    int          n_chk;
    int          n_fail;

    fetch_stage #(
        .RESET_PC  (C_RESET_PC),
        .NOP_INSTR (C_NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .stall_id        (stall_id),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ifid_valid      (ifid_valid),
        .ifid_pc         (ifid_pc),
        .ifid_instr      (ifid_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_bubbles    (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    // program_counter register: always loads pc_next
    always @(posedge clk) pc_cur <= pc_next;

    // Instruction memory contents: word = address ^ key
    assign imem_rdata = imem_addr ^ key;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        stl;
        logic        rdr;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_pcn;
        logic        e_v;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic a_rst, input logic a_rdy, input logic a_stl,
                       input logic a_rdr, input logic [31:0] a_tgt,
                       input logic a_req, input logic [31:0] a_pcn,
                       input logic a_v, input logic [31:0] a_pc);
        vec_t v;
        v.rst = a_rst; v.rdy = a_rdy; v.stl = a_stl; v.rdr = a_rdr; v.tgt = a_tgt;
        v.e_req = a_req; v.e_pcn = a_pcn; v.e_v = a_v; v.e_pc = a_pc;
        vecs.push_back(v);
    endtask

    // Reference-model state for the randomized run
    logic [31:0] exp_next;
    logic        prev_req, prev_rdy, prev_v, prev_stl, prev_rdr;
    logic [31:0] prev_addr;
    int          n_accept, n_written, n_bub;

    initial begin
        n_chk = 0;
        n_fail = 0;
        key = 32'd0;
        rst = 1'b1;
        imem_ready = 1'b1;
        stall_id = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;

        //   rst rdy stl rdr target         req pc_next        v  ifid_pc
        add(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h4,          0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'hC,          1, 32'h4);
        add(0, 1, 1, 0, 32'h0,          1, 32'h10,         1, 32'h8);
        add(0, 1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h8);
        add(0, 1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h8);
        add(0, 1, 0, 0, 32'h0,          0, 32'h10,         1, 32'h8);
        add(0, 0, 0, 0, 32'h0,          1, 32'h10,         1, 32'hC);
        add(0, 0, 0, 0, 32'h0,          1, 32'h10,         0, 32'h0);
        add(0, 0, 0, 0, 32'h0,          1, 32'h10,         0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h14,         0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h18,         1, 32'h10);
        add(0, 1, 0, 0, 32'h0,          1, 32'h1C,         1, 32'h14);
        add(0, 1, 0, 0, 32'h0,          1, 32'h20,         1, 32'h18);
        add(0, 0, 0, 0, 32'h0,          1, 32'h20,         1, 32'h1C);
        add(0, 0, 0, 1, 32'h100,        1, 32'h20,         0, 32'h0);
        add(0, 0, 0, 0, 32'h0,          1, 32'h20,         0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h100,        0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h104,        0, 32'h0);
        add(0, 1, 1, 0, 32'h0,          1, 32'h108,        1, 32'h100);
        add(0, 1, 0, 1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC,  1, 32'h100);
        add(0, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h4,          1, 32'hFFFF_FFFC);
        add(0, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0);
        add(0, 1, 0, 1, 32'h40,         0, 32'h40,         1, 32'h4);
        add(0, 1, 0, 0, 32'h0,          1, 32'h44,         0, 32'h0);
        add(0, 0, 0, 0, 32'h0,          1, 32'h44,         1, 32'h40);
        add(0, 0, 0, 1, 32'h200,        1, 32'h44,         0, 32'h0);
        add(0, 0, 0, 1, 32'h300,        1, 32'h44,         0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h300,        0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h304,        0, 32'h0);
        add(0, 0, 0, 0, 32'h0,          1, 32'h304,        1, 32'h300);
        add(0, 0, 0, 1, 32'h400,        1, 32'h304,        0, 32'h0);
        add(0, 1, 0, 1, 32'h500,        1, 32'h500,        0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h504,        0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h508,        1, 32'h500);
        add(0, 0, 0, 0, 32'h0,          1, 32'h508,        1, 32'h504);
        add(0, 1, 0, 1, 32'h600,        1, 32'h508,        0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h600,        0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h604,        0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 32'h608,        1, 32'h600);

        @(posedge clk);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst             = vecs[i].rst;
            imem_ready      = vecs[i].rdy;
            stall_id        = vecs[i].stl;
            redirect_valid  = vecs[i].rdr;
            redirect_target = vecs[i].tgt;
            @(negedge clk);
            chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d pc_next", i), pc_next, vecs[i].e_pcn);
            chk($sformatf("v%0d imem_addr", i), imem_addr, pc_cur);
            chk($sformatf("v%0d ifid_valid", i), {31'd0, ifid_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("v%0d ifid_instr", i), ifid_instr, vecs[i].e_v ? vecs[i].e_pc : C_NOP);
            if (vecs[i].e_v || vecs[i].rst)
                chk($sformatf("v%0d ifid_pc", i), ifid_pc, vecs[i].e_pc);
        end

        // Reset while a request is outstanding
        @(posedge clk); #1;
        imem_ready = 1'b0; stall_id = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("rstmid fetch req", {31'd0, imem_req}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid wait req", {31'd0, imem_req}, 32'd1);
        chk("rstmid wait hold", pc_next, pc_cur);
        @(posedge clk); #1;
        rst = 1'b1; imem_ready = 1'b1;
        @(negedge clk);
        chk("rstmid req in rst", {31'd0, imem_req}, 32'd0);
        chk("rstmid pc_next in rst", pc_next, C_RESET_PC);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid boot valid", {31'd0, ifid_valid}, 32'd0);
        chk("rstmid boot instr", ifid_instr, C_NOP);
        chk("rstmid boot pc", ifid_pc, 32'd0);
        chk("rstmid boot req", {31'd0, imem_req}, 32'd0);
        chk("rstmid boot pc_next", pc_next, C_RESET_PC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid first req", {31'd0, imem_req}, 32'd1);
        chk("rstmid first addr", imem_addr, C_RESET_PC);
        chk("rstmid first pc_next", pc_next, C_RESET_PC + 32'd4);

        // Randomized run against an instruction-stream model
        key = 32'h5A5A_3C00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_next  = C_RESET_PC;
        prev_req  = 1'b0; prev_rdy = 1'b0; prev_v = 1'b0;
        prev_stl  = 1'b0; prev_rdr = 1'b0; prev_addr = 32'd0;
        n_accept  = 0; n_written = 0; n_bub = 0;
        for (int k = 0; k < C_NRAND; k++) begin
            imem_ready     = ($urandom_range(0, 3) != 0);
            stall_id       = ($urandom_range(0, 3) == 0);
            redirect_valid = (k > 0) && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0)
                redirect_target = 32'hFFFF_FFF8;
            else
                redirect_target = 32'($urandom_range(0, 1023)) << 2;
            @(negedge clk);

            chk($sformatf("r%0d addr", k), imem_addr, pc_cur);
            if (!ifid_valid)
                chk($sformatf("r%0d nop", k), ifid_instr, C_NOP);
            if (prev_req && !prev_rdy) begin
                chk($sformatf("r%0d req stable", k), {31'd0, imem_req}, 32'd1);
                chk($sformatf("r%0d addr stable", k), imem_addr, prev_addr);
            end
            if (!(imem_req && imem_ready) && !redirect_valid)
                chk($sformatf("r%0d pc hold", k), pc_next, pc_cur);
            if (ifid_valid && !stall_id) begin
                chk($sformatf("r%0d deliver pc", k), ifid_pc, exp_next);
                chk($sformatf("r%0d deliver instr", k), ifid_instr, ifid_pc ^ key);
                exp_next = ifid_pc + 32'd4;
                n_accept++;
            end
            if (redirect_valid)
                exp_next = redirect_target;
            if (ifid_valid && !(prev_v && prev_stl && !prev_rdr))
                n_written++;
`ifdef FETCH_PERF_EN
            if (k == C_NRAND - 1) begin
                chk("perf_fetched", perf_fetched, 32'(n_written));
                chk("perf_bubbles", perf_bubbles, 32'(n_bub));
            end
`endif
            if (k > 0 && !ifid_valid && !stall_id)
                n_bub++;

            prev_req  = imem_req;
            prev_rdy  = imem_ready;
            prev_addr = imem_addr;
            prev_v    = ifid_valid;
            prev_stl  = stall_id;
            prev_rdr  = redirect_valid;
            @(posedge clk); #1;
        end
        chk("random liveness", {31'd0, n_accept >= 300}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
